mult_result_accumulator: RTL and testbench

//  Downstream stage of the one-cycle array multiplier. Consumes a stream of RW-bit products

---
 rtl/mult_result_accumulator_pkg.sv | 21 ++
 rtl/mult_result_accumulator_if.sv | 32 +++
 rtl/mult_result_accumulator.sv | 85 ++++++++
 tb/tb_mult_result_accumulator.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_result_accumulator_pkg.sv
// Shared types and width helpers for the multiplier result accumulator.
package mult_pkg;

   localparam int unsigned DW_DEFAULT  = 4;
   localparam int unsigned LEN_DEFAULT = 4;

   typedef enum logic {
      ACC  = 1'b0,
      HOLD = 1'b1
   } acc_state_e;

   function automatic int unsigned rw_f(input int unsigned dw);
      return dw + dw;
   endfunction

   // Sum width grows by log2(LEN) so a full frame of maximal products cannot overflow.
   function automatic int unsigned aw_f(input int unsigned dw, input int unsigned len);
      return rw_f(dw) + $clog2(len);
   endfunction

endpackage

// File: rtl/mult_result_accumulator_if.sv
// Product-in / frame-sum-out valid/ready bundle for the accumulator.
interface mult_result_accumulator_if #(
   parameter int unsigned RW = 8,
   parameter int unsigned AW = 10
);

   logic          in_vld;
   logic          in_rdy;
   logic [RW-1:0] in_data;
   logic          out_vld;
   logic          out_rdy;
   logic [AW-1:0] out_data;

   modport master (
      output in_vld,
      output in_data,
      output out_rdy,
      input  in_rdy,
      input  out_vld,
      input  out_data
   );

   modport slave (
      input  in_vld,
      input  in_data,
      input  out_rdy,
      output in_rdy,
      output out_vld,
      output out_data
   );

endinterface

// File: rtl/mult_result_accumulator.sv
// Sums frames of LEN products from the multiplier and presents each sum on a held output.
module mult_result_accumulator
   import mult_pkg::*;
#(
   parameter int unsigned DW  = DW_DEFAULT,
   parameter int unsigned LEN = LEN_DEFAULT,
   parameter int unsigned RW  = rw_f(DW),
   parameter int unsigned CW  = $clog2(LEN),
   parameter int unsigned AW  = aw_f(DW, LEN)
) (
   input logic                      clk,
   input logic                      rst,
   input logic                      clr,
   mult_result_accumulator_if.slave bus
);

   localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

   acc_state_e    r_state;
   acc_state_e    w_state_nxt;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic          r_out_vld;
   logic [AW-1:0] r_out_data;
   logic          w_in_rdy;
   logic          w_fire;
   logic          w_last;
   logic [AW-1:0] w_beat;

   // While holding a sum, a new beat is only taken in the cycle the sum drains.
   assign w_in_rdy = ~clr & ((r_state == ACC) | bus.out_rdy);
   assign w_fire   = bus.in_vld & w_in_rdy;
   assign w_last   = (r_cnt == LAST_CNT);
   assign w_beat   = AW'(bus.in_data);

   assign bus.in_rdy   = w_in_rdy;
   assign bus.out_vld  = r_out_vld;
   assign bus.out_data = r_out_data;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ACC:     if (w_fire && w_last) w_state_nxt = HOLD;
         HOLD:    if (bus.out_rdy) w_state_nxt = ACC;
         default: w_state_nxt = ACC;
      endcase
      if (clr) w_state_nxt = ACC;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ACC;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_out_vld  <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (clr) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out_vld <= 1'b0;
         end else if (r_state == ACC) begin
            if (w_fire) begin
               if (w_last) begin
                  r_out_data <= r_acc + w_beat;
                  r_out_vld  <= 1'b1;
                  r_acc      <= '0;
                  r_cnt      <= '0;
               end else begin
                  r_acc <= r_acc + w_beat;
                  r_cnt <= r_cnt + CW'(1);
               end
            end
         end else if (bus.out_rdy) begin
            r_out_vld <= 1'b0;
            if (w_fire) begin
               r_acc <= w_beat;
               r_cnt <= CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_mult_result_accumulator.sv
// Directed bench: driver pushes expected frame sums, a monitor pops them on each output transfer.
module tb_mult_result_accumulator;

   localparam int unsigned DW  = 4;
   localparam int unsigned LEN = 4;
   localparam int unsigned RW  = 8;
   localparam int unsigned AW  = 10;

   logic clk;
   logic rst;
   logic clr;

   int n_tests;
   int n_fail;
   int sb[$];

   mult_result_accumulator_if #(.RW(RW), .AW(AW)) bus ();

   mult_result_accumulator #(
      .DW  (DW),
      .LEN (LEN)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: values seen 2 time units after negedge are what the next posedge samples.
   always begin
      @(negedge clk);
      #2;
      if (bus.out_vld && bus.out_rdy && !rst) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", int'(bus.out_data), -1);
         end else begin
            chk("frame_sum", int'(bus.out_data), sb.pop_front());
         end
      end
   end

   task automatic send(input logic [RW-1:0] d);
      int waitc;
      waitc = 0;
      @(negedge clk);
      bus.in_vld  = 1'b1;
      bus.in_data = d;
      #1;
      while (!bus.in_rdy) begin
         if (waitc >= 20) begin
            chk("in_rdy_timeout", 0, 1);
            break;
         end
         @(negedge clk);
         #1;
         waitc++;
      end
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.in_vld  = 1'b0;
         bus.in_data = 8'hFF;
         @(posedge clk);
      end
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      rst         = 1'b1;
      clr         = 1'b0;
      bus.in_vld  = 1'b0;
      bus.in_data = '0;
      bus.out_rdy = 1'b1;

      // 1: reset values visible without a clock edge
      #1;
      chk("rst_out_vld", int'(bus.out_vld), 0);
      chk("rst_out_data", int'(bus.out_data), 0);
      chk("rst_in_rdy", int'(bus.in_rdy), 1);
      #12;
      rst = 1'b0;
      idle(2);

      // 2: max products back-to-back
      sb.push_back(900);
      for (int i = 0; i < 4; i++) send(8'd225);
      idle(3);

      // 3: output backpressure, then drain with a same-cycle beat
      bus.out_rdy = 1'b0;
      sb.push_back(10);
      for (int i = 1; i <= 4; i++) send(8'(i));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_vld  = 1'b1;
         bus.in_data = 8'd7;
         #1;
         chk("hold_in_rdy", int'(bus.in_rdy), 0);
         chk("hold_out_vld", int'(bus.out_vld), 1);
         chk("hold_out_data", int'(bus.out_data), 10);
         @(posedge clk);
      end
      @(negedge clk);
      bus.out_rdy = 1'b1;
      #1;
      chk("drain_in_rdy", int'(bus.in_rdy), 1);
      @(posedge clk);
      sb.push_back(10);
      for (int i = 0; i < 3; i++) send(8'd1);
      idle(3);

      // 4: clr discards a partial frame
      send(8'd5);
      send(8'd6);
      @(negedge clk);
      bus.in_vld = 1'b1;
      clr        = 1'b1;
      #1;
      chk("clr_in_rdy", int'(bus.in_rdy), 0);
      @(posedge clk);
      @(negedge clk);
      clr        = 1'b0;
      bus.in_vld = 1'b0;
      #1;
      chk("clr_out_data_kept", int'(bus.out_data), 10);
      sb.push_back(4);
      for (int i = 0; i < 4; i++) send(8'd1);
      idle(3);

      // 5: invalid cycles carry garbage data that must be ignored
      sb.push_back(12);
      for (int i = 0; i < 4; i++) begin
         send(8'd3);
         idle(i + 1);
      end
      idle(2);

      // 6: asynchronous reset mid-frame
      for (int i = 0; i < 3; i++) send(8'd9);
      @(negedge clk);
      bus.in_vld = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_vld", int'(bus.out_vld), 0);
      chk("mid_rst_out_data", int'(bus.out_data), 0);
      chk("mid_rst_in_rdy", int'(bus.in_rdy), 1);
      #1;
      rst = 1'b0;
      sb.push_back(8);
      for (int i = 0; i < 4; i++) send(8'd2);
      idle(1);
      @(negedge clk);
      #1;
      chk("final_out_data", int'(bus.out_data), 8);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
